ttt_turn_ctrl: RTL and testbench

TTT_TURN_CTRL -- requirements
Module: ttt_turn_ctrl

---
 rtl/ttt_turn_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ttt_turn_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ttt_turn_ctrl.sv
// Turn sequencer for a tic-tac-toe board: arbitrates player/computer moves and
// issues board writes. Define TURN_TIMEOUT_EN to enable the per-turn timeout.
module ttt_turn_ctrl #(
    parameter int FIRST_SIDE     = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       plyr_req,
    input  logic [3:0] plyr_slot,
    input  logic       comp_req,
    input  logic [3:0] comp_slot,
    input  logic       game_over,
    output logic [1:0] turn,
    output logic       wr_en,
    output logic [3:0] wr_slot,
    output logic [1:0] wr_who,
    output logic       plyr_ack,
    output logic       comp_ack,
    output logic       invalid,
    output logic       timeout,
    output logic [3:0] move_cnt,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, P_TURN, C_TURN, DONE} state_t;

    localparam state_t START_STATE = (FIRST_SIDE == 2) ? C_TURN : P_TURN;

    state_t     state_reg, state_next;
    logic [8:0] shadow_reg, shadow_next;
    logic [3:0] move_cnt_reg, move_cnt_next;
    logic [1:0] turn_reg, turn_next;
    logic       done_reg, done_next;
    logic       wr_en_reg, wr_en_next;
    logic [3:0] wr_slot_reg, wr_slot_next;
    logic [1:0] wr_who_reg, wr_who_next;
    logic       plyr_ack_reg, plyr_ack_next;
    logic       comp_ack_reg, comp_ack_next;
    logic       invalid_reg, invalid_next;

    logic       is_p;
    logic       in_turn;
    logic       act_req;
    logic [3:0] act_slot;
    logic [8:0] slot_mask;
    logic       accept;

    assign is_p     = (state_reg == P_TURN);
    assign in_turn  = (state_reg == P_TURN) || (state_reg == C_TURN);
    assign act_req  = is_p ? plyr_req : comp_req;
    assign act_slot = is_p ? plyr_slot : comp_slot;

    // One-hot of the requested slot; all-zero for out-of-range slots 9..15.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_mask
            assign slot_mask[gi] = (act_slot == 4'(gi));
        end
    endgenerate

    assign accept = act_req && (slot_mask != 9'd0) && ((shadow_reg & slot_mask) == 9'd0);

`ifdef TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmr_reg, tmr_next;
    logic          timeout_reg, timeout_next;
`endif

    always_comb begin
        state_next    = state_reg;
        shadow_next   = shadow_reg;
        move_cnt_next = move_cnt_reg;
        wr_en_next    = 1'b0;
        wr_slot_next  = 4'd0;
        wr_who_next   = 2'd0;
        plyr_ack_next = 1'b0;
        comp_ack_next = 1'b0;
        invalid_next  = 1'b0;
`ifdef TURN_TIMEOUT_EN
        tmr_next      = '0;
        timeout_next  = 1'b0;
`endif
        if (start) begin
            state_next    = START_STATE;
            shadow_next   = 9'd0;
            move_cnt_next = 4'd0;
        end else if (in_turn) begin
            if (game_over) begin
                state_next = DONE;
            end else if (accept) begin
                wr_en_next    = 1'b1;
                wr_slot_next  = act_slot;
                wr_who_next   = is_p ? 2'd1 : 2'd2;
                plyr_ack_next = is_p;
                comp_ack_next = !is_p;
                shadow_next   = shadow_reg | slot_mask;
                move_cnt_next = move_cnt_reg + 4'd1;
                state_next    = (move_cnt_reg == 4'd8) ? DONE : (is_p ? C_TURN : P_TURN);
            end else begin
                invalid_next = act_req;
`ifdef TURN_TIMEOUT_EN
                // Expired turn passes to the other side without a board write.
                if (tmr_reg == TMR_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = is_p ? C_TURN : P_TURN;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
`endif
            end
        end
        turn_next = (state_next == P_TURN) ? 2'd1 : (state_next == C_TURN) ? 2'd2 : 2'd0;
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            shadow_reg   <= 9'd0;
            move_cnt_reg <= 4'd0;
            turn_reg     <= 2'd0;
            done_reg     <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_slot_reg  <= 4'd0;
            wr_who_reg   <= 2'd0;
            plyr_ack_reg <= 1'b0;
            comp_ack_reg <= 1'b0;
            invalid_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shadow_reg   <= shadow_next;
            move_cnt_reg <= move_cnt_next;
            turn_reg     <= turn_next;
            done_reg     <= done_next;
            wr_en_reg    <= wr_en_next;
            wr_slot_reg  <= wr_slot_next;
            wr_who_reg   <= wr_who_next;
            plyr_ack_reg <= plyr_ack_next;
            comp_ack_reg <= comp_ack_next;
            invalid_reg  <= invalid_next;
        end
    end

`ifdef TURN_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            tmr_reg     <= tmr_next;
            timeout_reg <= timeout_next;
        end
    end
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    assign turn     = turn_reg;
    assign done     = done_reg;
    assign move_cnt = move_cnt_reg;
    assign wr_en    = wr_en_reg;
    assign wr_slot  = wr_slot_reg;
    assign wr_who   = wr_who_reg;
    assign plyr_ack = plyr_ack_reg;
    assign comp_ack = comp_ack_reg;
    assign invalid  = invalid_reg;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed self-checking bench for ttt_turn_ctrl (default parameters).
module tb_ttt_turn_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       plyr_req;
    logic [3:0] plyr_slot;
    logic       comp_req;
    logic [3:0] comp_slot;
    logic       game_over;
    logic [1:0] turn;
    logic       wr_en;
    logic [3:0] wr_slot;
    logic [1:0] wr_who;
    logic       plyr_ack;
    logic       comp_ack;
    logic       invalid;
    logic       timeout;
    logic [3:0] move_cnt;
    logic       done;

    int n_checks = 0;
    int n_fails  = 0;

    ttt_turn_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .plyr_req(plyr_req), .plyr_slot(plyr_slot),
        .comp_req(comp_req), .comp_slot(comp_slot),
        .game_over(game_over), .turn(turn),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_who(wr_who),
        .plyr_ack(plyr_ack), .comp_ack(comp_ack),
        .invalid(invalid), .timeout(timeout),
        .move_cnt(move_cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        start = 0; plyr_req = 0; comp_req = 0; game_over = 0;
        plyr_slot = 0; comp_slot = 0;
    endtask

    // Present one request for a single edge, then sample the registered response.
    task automatic req(input bit p, input logic [3:0] s);
        if (p) begin plyr_req = 1; plyr_slot = s; end
        else   begin comp_req = 1; comp_slot = s; end
        cycle();
        clear_in();
        $display("req %s slot %0d -> wr_en=%0d who=%0d inv=%0d turn=%0d cnt=%0d",
                 p ? "plyr" : "comp", s, wr_en, wr_who, invalid, turn, move_cnt);
    endtask

    task automatic do_start();
        start = 1;
        cycle();
        clear_in();
        $display("start -> turn=%0d cnt=%0d done=%0d", turn, move_cnt, done);
    endtask

    initial begin
        clear_in();
        reset = 1;
        #12;
        chk("rst_turn", turn, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", move_cnt, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_timeout", timeout, 0);
        cycle();
        reset = 0;
        cycle(); cycle();
        chk("idle_hold_turn", turn, 0);
        req(1, 4'd0);
        chk("idle_req_ignored", wr_en, 0);

        do_start();
        chk("start_turn", turn, 1);
        chk("start_cnt", move_cnt, 0);

        req(1, 4'd0);
        chk("m1_wr_en", wr_en, 1);
        chk("m1_wr_slot", wr_slot, 0);
        chk("m1_wr_who", wr_who, 1);
        chk("m1_plyr_ack", plyr_ack, 1);
        chk("m1_turn", turn, 2);
        chk("m1_cnt", move_cnt, 1);
        cycle();
        chk("m1_pulse_end", wr_en, 0);

        req(0, 4'd0);
        chk("occ_invalid", invalid, 1);
        chk("occ_no_wr", wr_en, 0);
        chk("occ_turn", turn, 2);
        cycle();
        chk("inv_pulse_end", invalid, 0);

        req(0, 4'd1);
        chk("m2_wr_who", wr_who, 2);
        chk("m2_wr_slot", wr_slot, 1);
        chk("m2_comp_ack", comp_ack, 1);
        chk("m2_turn", turn, 1);

        req(0, 4'd4);
        chk("inact_comp_wr", wr_en, 0);
        chk("inact_comp_inv", invalid, 0);
        req(1, 4'd9);
        chk("slot9_invalid", invalid, 1);
        chk("slot9_turn", turn, 1);
        chk("slot9_cnt", move_cnt, 2);

        req(1, 4'd2);
        chk("m3_turn", turn, 2);
        req(1, 4'd4);
        chk("inact_plyr_wr", wr_en, 0);
        chk("inact_plyr_inv", invalid, 0);
        chk("inact_plyr_turn", turn, 2);

        for (int s = 3; s <= 8; s++) begin
            req((s % 2) == 0, 4'(s));
            chk("fill_wr_en", wr_en, 1);
            chk("fill_cnt", move_cnt, s + 1);
        end
        chk("full_done", done, 1);
        chk("full_turn", turn, 0);
        req(0, 4'd0);
        chk("done_ign_wr", wr_en, 0);
        chk("done_ign_inv", invalid, 0);
        chk("done_cnt_hold", move_cnt, 9);

        do_start();
        chk("restart_cnt", move_cnt, 0);
        chk("restart_done", done, 0);
        for (int s = 0; s < 5; s++) req((s % 2) == 0, 4'(s));
        chk("m5_cnt", move_cnt, 5);
        chk("m5_turn", turn, 2);
        game_over = 1; comp_req = 1; comp_slot = 4'd5;
        cycle();
        clear_in();
        chk("go_done", done, 1);
        chk("go_turn", turn, 0);
        chk("go_req_ign", wr_en, 0);
        chk("go_cnt", move_cnt, 5);
        do_start();
        chk("go_restart_cnt", move_cnt, 0);
        chk("go_restart_turn", turn, 1);
        req(1, 4'd0);
        chk("reuse_slot0", plyr_ack, 1);

        start = 1; comp_req = 1; comp_slot = 4'd3;
        cycle();
        clear_in();
        chk("abort_no_wr", wr_en, 0);
        chk("abort_turn", turn, 1);
        chk("abort_cnt", move_cnt, 0);

`ifdef TURN_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            cycle();
            chk("to_wait", timeout, 0);
        end
        cycle();
        chk("to_pulse", timeout, 1);
        chk("to_turn", turn, 2);
        chk("to_cnt", move_cnt, 0);
        chk("to_no_wr", wr_en, 0);
        cycle();
        chk("to_pulse_end", timeout, 0);
        do_start();
`endif

        req(1, 4'd6);
        chk("pre_rst_wr", wr_en, 1);
        reset = 1;
        #1;
        chk("async_wr_en", wr_en, 0);
        chk("async_ack", plyr_ack, 0);
        chk("async_turn", turn, 0);
        chk("async_cnt", move_cnt, 0);
        cycle();
        reset = 0;
        cycle();
        chk("post_rst_idle", turn, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
